// File: rtl/sw_array_feeder.sv
// Head-of-array feeder for the Smith-Waterman PE chain: loads the target, replays tail PE words for multi-pass queries.
// Latency: a pop reaches the PE0 outputs one cycle later; the first pop follows the last target symbol by one cycle.
// Backpressure: t_ready is high only while the target is loading; an issue burst never stalls; tail words are never refused.
// Optional build macro SW_FEEDER_ERR_CHK_EN enables the sticky err flag; without it err is tied low.

`ifndef V_E_F_Bit
`define V_E_F_Bit 16
`endif

module sw_array_feeder #(
    parameter int ADDR_W    = 8,
    parameter int T_MAX_LEN = 2**ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W:0]       t_len,
    input  logic [7:0]            num_pass,
    input  logic [`V_E_F_Bit-1:0] minusAlpha,
    input  logic                  t_valid,
    output logic                  t_ready,
    input  logic [1:0]            t_data,
    input  logic                  tail_valid,
    input  logic [1:0]            tail_t,
    input  logic [`V_E_F_Bit-1:0] tail_v,
    input  logic [`V_E_F_Bit-1:0] tail_f,
    output logic                  pe_enable,
    output logic                  pe_newLine,
    output logic [1:0]            pe_t,
    output logic [`V_E_F_Bit-1:0] pe_v,
    output logic [`V_E_F_Bit-1:0] pe_v_alpha,
    output logic [`V_E_F_Bit-1:0] pe_f,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int W = `V_E_F_Bit;
    localparam logic [ADDR_W:0]   MAX_CNT  = (ADDR_W+1)'(T_MAX_LEN);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(T_MAX_LEN - 1);

    typedef struct packed {
        logic [1:0]   t;
        logic [W-1:0] v;
        logic [W-1:0] f;
    } entry_t;

    typedef enum logic [1:0] {IDLE, FILL, ISSUE, WAIT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W:0]   len_q;
    logic [7:0]        npass_q;
    logic [7:0]        pass_idx;
    logic [ADDR_W:0]   fill_cnt;
    logic [ADDR_W:0]   pop_cnt;
    logic [ADDR_W:0]   tail_cnt;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              done_q;
    entry_t            mem [T_MAX_LEN];

    logic   params_ok, start_ok, fill_acc, capture, tail_push;
    logic   push, push_ok, full, pop, pop_last, tail_done, last_pass, bad_start;
    entry_t push_dat, pop_dat;

    assign params_ok = (t_len != '0) && (t_len <= MAX_CNT) && (num_pass != 8'd0);
    assign start_ok  = (state == IDLE) && start && !done_q && params_ok;
    assign bad_start = (state == IDLE) && start && !params_ok;
    assign t_ready   = (state == FILL) && (fill_cnt < len_q);
    assign fill_acc  = t_valid && t_ready;
    assign capture   = (state == ISSUE) || (state == WAIT);
    assign last_pass = (pass_idx >= npass_q);
    // Tail words of the final pass are only counted: nothing will replay them.
    assign tail_push = capture && tail_valid && !last_pass;
    assign push      = fill_acc || tail_push;
    assign full      = (count == MAX_CNT);
    assign push_ok   = push && !full;
    assign pop       = (state == ISSUE);
    assign pop_last  = pop && (pop_cnt == len_q - 1'b1);
    assign tail_done = (state == WAIT) && (tail_cnt == len_q);
    assign pop_dat   = mem[rd_ptr];
    assign busy      = (state != IDLE) || done_q;
    assign done      = done_q;

    // Select what enters the pass buffer: fresh target symbols or replayed tail words.
    always_comb begin
        push_dat = '{t: tail_t, v: tail_v, f: tail_f};
        if (fill_acc) begin
            push_dat = '{t: t_data, v: '0, f: '0};
        end
    end

    // Next-state logic of the job sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = FILL;
            FILL:    if (fill_acc && (fill_cnt + 1'b1 == len_q)) state_nxt = ISSUE;
            ISSUE:   if (pop_last) state_nxt = WAIT;
            WAIT:    if (tail_done) state_nxt = last_pass ? IDLE : ISSUE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Job parameters and pass/fill/pop/tail counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q    <= '0;
            npass_q  <= '0;
            pass_idx <= '0;
            fill_cnt <= '0;
            pop_cnt  <= '0;
            tail_cnt <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= tail_done && last_pass;
            if (start_ok) begin
                len_q    <= t_len;
                npass_q  <= num_pass;
                pass_idx <= 8'd1;
                fill_cnt <= '0;
                pop_cnt  <= '0;
                tail_cnt <= '0;
            end else begin
                if (fill_acc) fill_cnt <= fill_cnt + 1'b1;
                if (pop)      pop_cnt  <= pop_last ? '0 : pop_cnt + 1'b1;
                if (tail_done) begin
                    tail_cnt <= '0;
                    if (!last_pass) pass_idx <= pass_idx + 8'd1;
                end else if (capture && tail_valid) begin
                    tail_cnt <= tail_cnt + 1'b1;
                end
            end
        end
    end

    // Pass-buffer pointers and occupancy; pointers wrap at the buffer depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (start_ok) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)     rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Buffer storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

    // Registered PE0 drive; all zero in cycles without a pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pe_enable  <= 1'b0;
            pe_newLine <= 1'b0;
            pe_t       <= '0;
            pe_v       <= '0;
            pe_v_alpha <= '0;
            pe_f       <= '0;
        end else begin
            pe_enable  <= pop;
            pe_newLine <= pop && (pop_cnt == '0);
            pe_t       <= pop ? pop_dat.t : 2'b00;
            pe_v       <= pop ? pop_dat.v : '0;
            pe_v_alpha <= pop ? pop_dat.v + minusAlpha : '0;
            pe_f       <= pop ? pop_dat.f : '0;
        end
    end

`ifdef SW_FEEDER_ERR_CHK_EN
    // Sticky flag for dropped pushes, stray tail words and illegal starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err <= 1'b0;
        else if ((push && full) || (tail_valid && !capture) || bad_start) err <= 1'b1;
    end
`else
    assign err = 1'b0;
    // Keep the checker inputs referenced so the unchecked build stays warning-free.
    logic unused_chk;
    assign unused_chk = &{1'b0, full, bad_start};
`endif

endmodule

// File: tb/tb_sw_array_feeder.sv
`ifndef V_E_F_Bit
`define V_E_F_Bit 16
`endif

module tb_sw_array_feeder;

    localparam int W = `V_E_F_Bit;
`ifdef SW_FEEDER_ERR_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [8:0]   t_len = '0;
    logic [7:0]   num_pass = '0;
    logic [W-1:0] minusAlpha = '0;
    logic         t_valid = 1'b0;
    logic         t_ready;
    logic [1:0]   t_data = '0;
    logic         tail_valid = 1'b0;
    logic [1:0]   tail_t = '0;
    logic [W-1:0] tail_v = '0;
    logic [W-1:0] tail_f = '0;
    logic         pe_enable, pe_newLine;
    logic [1:0]   pe_t;
    logic [W-1:0] pe_v, pe_v_alpha, pe_f;
    logic         busy, done, err;

    int checks = 0;
    int failures = 0;

    // Job stimulus: target symbols and the words the tail PE returns in each pass.
    logic [1:0]   sym [256];
    logic [1:0]   tt  [4][256];
    logic [W-1:0] tv  [4][256];
    logic [W-1:0] tf  [4][256];
    // What PE0 actually received, per pass.
    logic [1:0]   cap_t  [4][256];
    logic [W-1:0] cap_v  [4][256];
    logic [W-1:0] cap_va [4][256];
    logic [W-1:0] cap_f  [4][256];

    typedef struct {
        int tl;
        int np;
        bit accept;
    } start_vec_t;

    sw_array_feeder dut (
        .clk(clk), .rst(rst), .start(start), .t_len(t_len), .num_pass(num_pass),
        .minusAlpha(minusAlpha), .t_valid(t_valid), .t_ready(t_ready), .t_data(t_data),
        .tail_valid(tail_valid), .tail_t(tail_t), .tail_v(tail_v), .tail_f(tail_f),
        .pe_enable(pe_enable), .pe_newLine(pe_newLine), .pe_t(pe_t), .pe_v(pe_v),
        .pe_v_alpha(pe_v_alpha), .pe_f(pe_f), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic quiet_inputs();
        start = 1'b0; t_valid = 1'b0; tail_valid = 1'b0;
        t_data = '0; tail_t = '0; tail_v = '0; tail_f = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        quiet_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic fill_rand(input int tl);
        for (int i = 0; i < tl; i++) begin
            sym[i] = 2'($urandom);
            for (int p = 0; p < 4; p++) begin
                tt[p][i] = 2'($urandom);
                tv[p][i] = W'($urandom);
                tf[p][i] = W'($urandom);
            end
        end
    endtask

    // Runs one job: drives the target (gapm 0 = continuous, 1 = every other cycle, 2 = random),
    // plays the tail PE (first tail word tdel cycles after each pass's first PE0 word),
    // and checks every PE0 word, its timing and the job-end handshake.
    task automatic run_job(input int tl, input int np, input int gapm, input int tdel, input int ma);
        int acc = 0, pass = 0, en_cnt = 0;
        int last_acc = -100, last_en = -100, last_tail = -100;
        int tail_i = 0, tail_pass = 0, tail_start = -1;
        int done_cnt = 0, done_cyc = -1;
        int max_cyc;
        bit fin = 1'b0;
        logic [1:0]   et;
        logic [W-1:0] ev, ef, eva;
        logic         idle_or;
        max_cyc = 4 * tl + np * (tl + tdel + 8) + 20;
        minusAlpha = W'(ma);
        t_len = 9'(tl);
        num_pass = 8'(np);
        for (int k = 0; k < max_cyc && !fin; k++) begin
            @(negedge clk);
            if (pe_enable) begin
                if (pass >= np) begin
                    chk("extra_pe_word", 32'(pass), 32'(np - 1));
                end else begin
                    if (pass == 0) begin
                        et = sym[en_cnt]; ev = '0; ef = '0;
                    end else begin
                        et = tt[pass-1][en_cnt]; ev = tv[pass-1][en_cnt]; ef = tf[pass-1][en_cnt];
                    end
                    eva = ev + W'(ma);
                    chk("pe_t", 32'(pe_t), 32'(et));
                    chk("pe_v", 32'(pe_v), 32'(ev));
                    chk("pe_f", 32'(pe_f), 32'(ef));
                    chk("pe_v_alpha", 32'(pe_v_alpha), 32'(eva));
                    chk("pe_newLine", 32'(pe_newLine), 32'(en_cnt == 0));
                    if (en_cnt == 0) begin
                        if (pass == 0) chk("first_pop_latency", 32'(k), 32'(last_acc + 2));
                        else           chk("next_pass_latency", 32'(k), 32'(last_tail + 3));
                        tail_start = k + tdel;
                    end else begin
                        chk("burst_gap", 32'(k), 32'(last_en + 1));
                    end
                    cap_t[pass][en_cnt] = pe_t;  cap_v[pass][en_cnt] = pe_v;
                    cap_va[pass][en_cnt] = pe_v_alpha; cap_f[pass][en_cnt] = pe_f;
                    last_en = k;
                    en_cnt++;
                    if (en_cnt == tl) begin
                        en_cnt = 0;
                        pass++;
                    end
                end
            end else begin
                idle_or = pe_newLine | (|pe_t) | (|pe_v) | (|pe_v_alpha) | (|pe_f);
                chk("idle_outputs_zero", 32'(idle_or), 32'd0);
            end
            chk("t_ready", 32'(t_ready), 32'(k >= 1 && acc < tl));
            if (done) begin
                done_cnt++;
                done_cyc = k;
                chk("done_time", 32'(k), 32'(last_tail + 2));
                chk("busy_at_done", 32'(busy), 32'd1);
            end else if (done_cyc >= 0 && k == done_cyc + 1) begin
                chk("busy_after_done", 32'(busy), 32'd0);
                fin = 1'b1;
            end
            // Inputs for this cycle.
            start = (k == 0);
            if (k >= 1 && acc < tl) begin
                case (gapm)
                    0:       t_valid = 1'b1;
                    1:       t_valid = (k % 2 == 1);
                    default: t_valid = 1'($urandom);
                endcase
                t_data = sym[acc];
            end else begin
                t_valid = 1'b0;
            end
            if (t_valid && t_ready) begin
                acc++;
                if (acc == tl) last_acc = k;
            end
            if (tail_start >= 0 && k >= tail_start && tail_pass < np) begin
                tail_valid = 1'b1;
                tail_t = tt[tail_pass][tail_i];
                tail_v = tv[tail_pass][tail_i];
                tail_f = tf[tail_pass][tail_i];
                tail_i++;
                if (tail_i == tl) begin
                    last_tail = k;
                    tail_i = 0;
                    tail_pass++;
                    tail_start = -1;
                end
            end else begin
                tail_valid = 1'b0;
            end
        end
        quiet_inputs();
        chk("job_finished", 32'(fin), 32'd1);
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("passes_issued", 32'(pass), 32'(np));
    endtask

    initial begin
        start_vec_t tab [5];
        tab[0] = '{tl: 4,   np: 1, accept: 1'b1};
        tab[1] = '{tl: 0,   np: 1, accept: 1'b0};
        tab[2] = '{tl: 257, np: 1, accept: 1'b0};
        tab[3] = '{tl: 3,   np: 0, accept: 1'b0};
        tab[4] = '{tl: 256, np: 2, accept: 1'b1};

        // Reset state.
        @(negedge clk);
        chk("rst_pe_enable", 32'(pe_enable), 32'd0);
        chk("rst_t_ready", 32'(t_ready), 32'd0);
        chk("rst_busy_done_err", 32'({busy, done, err}), 32'd0);
        chk("rst_pe_data", 32'(pe_newLine | (|pe_t) | (|pe_v) | (|pe_v_alpha) | (|pe_f)), 32'd0);
        rst = 1'b1;

        // Start acceptance table.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            @(negedge clk);
            start = 1'b1; t_len = 9'(tab[i].tl); num_pass = 8'(tab[i].np);
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("start_busy_%0d", i), 32'(busy), 32'(tab[i].accept));
            chk($sformatf("start_err_%0d", i), 32'(err), 32'(ERR_EN && !tab[i].accept));
        end

        // Stray tail word while idle.
        do_reset();
        @(negedge clk); tail_valid = 1'b1;
        @(negedge clk); tail_valid = 1'b0;
        @(negedge clk);
        chk("idle_tail_busy", 32'(busy), 32'd0);
        chk("idle_tail_err", 32'(err), 32'(ERR_EN));
        do_reset();

        // Basic single pass, symbols 0..3, minusAlpha = -3.
        fill_rand(4);
        for (int i = 0; i < 4; i++) sym[i] = 2'(i);
        run_job(4, 1, 0, 1, -3);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_pe_t_%0d", i), 32'(cap_t[0][i]), i);
            chk($sformatf("t1_pe_va_%0d", i), 32'(cap_va[0][i]), 32'hFFFD);
            chk($sformatf("t1_pe_vf_%0d", i), 32'(cap_v[0][i] | cap_f[0][i]), 32'd0);
        end

        // Target arriving every other cycle.
        fill_rand(3);
        run_job(3, 1, 1, 0, -5);

        // Two passes with known tail words.
        fill_rand(3);
        for (int i = 0; i < 3; i++) begin
            tv[0][i] = W'(5 + i);
            tf[0][i] = W'(1 + i);
        end
        run_job(3, 2, 0, 0, -3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3_pe_v_%0d", i), 32'(cap_v[1][i]), 32'(5 + i));
            chk($sformatf("t3_pe_va_%0d", i), 32'(cap_va[1][i]), 32'(2 + i));
            chk($sformatf("t3_pe_f_%0d", i), 32'(cap_f[1][i]), 32'(1 + i));
        end

        // Full-depth target, three passes.
        fill_rand(256);
        run_job(256, 3, 0, 1, -7);
        chk("full_depth_err", 32'(err), 32'd0);

        // Randomized jobs.
        for (int j = 0; j < 8; j++) begin
            int tl, np, gm, td, ma;
            tl = int'($urandom_range(1, 24));
            np = int'($urandom_range(1, 4));
            gm = int'($urandom_range(0, 2));
            td = int'($urandom_range(0, 3));
            ma = -int'($urandom_range(1, 20));
            fill_rand(tl);
            run_job(tl, np, gm, td, ma);
        end
        chk("random_err", 32'(err), 32'd0);

        // Reset in the middle of an issue burst.
        fill_rand(4);
        @(negedge clk);
        start = 1'b1; t_len = 9'd4; num_pass = 8'd1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            t_valid = 1'b1; t_data = sym[i];
            @(negedge clk);
        end
        t_valid = 1'b0;
        for (int i = 0; i < 20 && !pe_enable; i++) @(negedge clk);
        chk("mid_issue_reached", 32'(pe_enable), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_pe", 32'(pe_enable | pe_newLine | (|pe_t) | (|pe_v) | (|pe_v_alpha) | (|pe_f)), 32'd0);
        chk("mid_rst_ctrl", 32'({busy, done, t_ready, err}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) sym[i] = 2'(3 - i);
        run_job(4, 1, 0, 1, -3);
        chk("post_rst_pe_t0", 32'(cap_t[0][0]), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
